// File: rtl/dram_port_arbiter.sv
// Two-port arbiter for the external DRAM port: one-deep request slot per port,
// round-robin grant, a single transaction in flight, optional ack timeout.
module dram_port_arbiter #(
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sync_reset,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic                  m0_read_en,
  input  logic                  m0_write_en,
  input  logic [DATA_W/8-1:0]   m0_byte_enable,
  input  logic [DATA_W-1:0]     m0_write_data,
  output logic                  m0_ack,
  output logic [DATA_W-1:0]     m0_read_data,
  output logic                  m0_err,
  output logic                  m0_busy,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic                  m1_read_en,
  input  logic                  m1_write_en,
  input  logic [DATA_W/8-1:0]   m1_byte_enable,
  input  logic [DATA_W-1:0]     m1_write_data,
  output logic                  m1_ack,
  output logic [DATA_W-1:0]     m1_read_data,
  output logic                  m1_err,
  output logic                  m1_busy,
  output logic [ADDR_W-1:0]     dram_addr,
  output logic                  dram_read_en,
  output logic                  dram_write_en,
  output logic [DATA_W/8-1:0]   dram_byte_enable,
  output logic [DATA_W-1:0]     dram_write_data,
  input  logic                  dram_ack,
  input  logic [DATA_W-1:0]     dram_read_data
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 2 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant;
  logic              w_grant_port;
  logic              w_done;
  logic              w_timeout;
  logic [CNT_W-1:0]  w_cnt_inc;

  logic [1:0]        w_req;
  logic [1:0]        w_req_wr;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [BE_W-1:0]   w_be    [2];
  logic [DATA_W-1:0] w_wdata [2];

  logic [1:0]        r_slot_vld;
  logic [1:0]        r_slot_wr;
  logic [ADDR_W-1:0] r_slot_addr [2];
  logic [BE_W-1:0]   r_slot_be   [2];
  logic [DATA_W-1:0] r_slot_data [2];

  logic              r_owner;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_ack;
  logic [1:0]        r_err;
  logic [DATA_W-1:0] r_rdata [2];
  logic [ADDR_W-1:0] r_dram_addr;
  logic              r_dram_rd;
  logic              r_dram_wr;
  logic [BE_W-1:0]   r_dram_be;
  logic [DATA_W-1:0] r_dram_wdata;

  // Per-port views of the request inputs; read+write together counts as a write
  assign w_req    = {m1_read_en | m1_write_en, m0_read_en | m0_write_en};
  assign w_req_wr = {m1_write_en, m0_write_en};
  assign w_addr[0]  = m0_addr;
  assign w_addr[1]  = m1_addr;
  assign w_be[0]    = m0_byte_enable;
  assign w_be[1]    = m1_byte_enable;
  assign w_wdata[0] = m0_write_data;
  assign w_wdata[1] = m1_write_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_state <= S_IDLE;
    else if (sync_reset) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  // Grant selection, completion and timeout detection
  always_comb begin
    w_state_nxt  = r_state;
    w_grant      = 1'b0;
    w_grant_port = 1'b0;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    w_cnt_inc    = r_cnt + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        if (r_slot_vld != 2'b00) begin
          w_grant      = 1'b1;
          w_grant_port = (r_slot_vld == 2'b11) ? ~r_last_grant : r_slot_vld[1];
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE, S_WAIT: begin
        if (dram_ack) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (TO_EN && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
          w_done      = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Slots, completion pulses and the registered DRAM command
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot_vld   <= '0;
      r_slot_wr    <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_dram_addr  <= '0;
      r_dram_rd    <= 1'b0;
      r_dram_wr    <= 1'b0;
      r_dram_be    <= '0;
      r_dram_wdata <= '0;
      for (int p = 0; p < 2; p++) begin
        r_slot_addr[p] <= '0;
        r_slot_be[p]   <= '0;
        r_slot_data[p] <= '0;
        r_rdata[p]     <= '0;
      end
    end else if (sync_reset) begin
      r_slot_vld   <= '0;
      r_slot_wr    <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_dram_addr  <= '0;
      r_dram_rd    <= 1'b0;
      r_dram_wr    <= 1'b0;
      r_dram_be    <= '0;
      r_dram_wdata <= '0;
      for (int p = 0; p < 2; p++) begin
        r_slot_addr[p] <= '0;
        r_slot_be[p]   <= '0;
        r_slot_data[p] <= '0;
        r_rdata[p]     <= '0;
      end
    end else begin
      r_dram_rd <= 1'b0;
      r_dram_wr <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        r_ack[p]   <= 1'b0;
        r_err[p]   <= 1'b0;
        r_rdata[p] <= '0;
        if (w_done && (r_owner == 1'(p))) begin
          r_ack[p]      <= 1'b1;
          r_err[p]      <= w_timeout;
          r_rdata[p]    <= (r_slot_wr[p] || w_timeout) ? '0 : dram_read_data;
          r_slot_vld[p] <= 1'b0;
        end
        // A capture on the edge that frees the slot overrides the clear
        if (w_req[p]) begin
          if (!r_slot_vld[p] || (w_done && (r_owner == 1'(p)))) begin
            r_slot_vld[p]  <= 1'b1;
            r_slot_wr[p]   <= w_req_wr[p];
            r_slot_addr[p] <= w_addr[p];
            r_slot_be[p]   <= w_be[p];
            r_slot_data[p] <= w_wdata[p];
          end else begin
            r_err[p] <= 1'b1;
          end
        end
      end
      if (w_grant) begin
        r_owner      <= w_grant_port;
        r_last_grant <= w_grant_port;
        r_cnt        <= '0;
        r_dram_addr  <= r_slot_addr[w_grant_port];
        r_dram_be    <= r_slot_be[w_grant_port];
        r_dram_wdata <= r_slot_data[w_grant_port];
        r_dram_rd    <= ~r_slot_wr[w_grant_port];
        r_dram_wr    <= r_slot_wr[w_grant_port];
      end else if (r_state != S_IDLE) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign m0_ack           = r_ack[0];
  assign m0_err           = r_err[0];
  assign m0_read_data     = r_rdata[0];
  assign m0_busy          = r_slot_vld[0];
  assign m1_ack           = r_ack[1];
  assign m1_err           = r_err[1];
  assign m1_read_data     = r_rdata[1];
  assign m1_busy          = r_slot_vld[1];
  assign dram_addr        = r_dram_addr;
  assign dram_read_en     = r_dram_rd;
  assign dram_write_en    = r_dram_wr;
  assign dram_byte_enable = r_dram_be;
  assign dram_write_data  = r_dram_wdata;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter: directed vectors plus a randomised
// two-port run against a DRAM responder with variable ack delay.
module tb_dram_port_arbiter;

  localparam int unsigned AW = 22;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 24;
  localparam int          NR = 400;

  localparam logic [AW-1:0] A0W = 22'h01_2340;
  localparam logic [AW-1:0] A0R = 22'h00_0F18;
  localparam logic [AW-1:0] A1R = 22'h2A_BCDE;
  localparam logic [AW-1:0] A1B = 22'h31_0004;

  logic clk = 1'b0;
  logic reset, sync_reset;
  logic [AW-1:0] m0_addr, m1_addr, dram_addr;
  logic m0_read_en, m0_write_en, m1_read_en, m1_write_en;
  logic [BW-1:0] m0_byte_enable, m1_byte_enable, dram_byte_enable;
  logic [DW-1:0] m0_write_data, m1_write_data, dram_write_data;
  logic m0_ack, m0_err, m0_busy, m1_ack, m1_err, m1_busy;
  logic [DW-1:0] m0_read_data, m1_read_data, dram_read_data;
  logic dram_read_en, dram_write_en, dram_ack;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
    logic          wr;
    int            cyc;
  } iss_t;
  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } ack_t;

  iss_t iss_q [2][$];
  ack_t ack_q [2][$];
  int   ovf_q [2][$];
  int   order_q [$];
  int   skip [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic resp_en, rand_delay, use_fixed, late_ack, resp_pending;
  int   resp_delay, resp_cnt;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] fixed_data;

  logic [1:0]    ack_v, err_v;
  logic [DW-1:0] rd_v [2];
  assign ack_v   = {m1_ack, m0_ack};
  assign err_v   = {m1_err, m0_err};
  assign rd_v[0] = m0_read_data;
  assign rd_v[1] = m1_read_data;

  dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .sync_reset(sync_reset),
    .m0_addr(m0_addr), .m0_read_en(m0_read_en), .m0_write_en(m0_write_en),
    .m0_byte_enable(m0_byte_enable), .m0_write_data(m0_write_data),
    .m0_ack(m0_ack), .m0_read_data(m0_read_data), .m0_err(m0_err), .m0_busy(m0_busy),
    .m1_addr(m1_addr), .m1_read_en(m1_read_en), .m1_write_en(m1_write_en),
    .m1_byte_enable(m1_byte_enable), .m1_write_data(m1_write_data),
    .m1_ack(m1_ack), .m1_read_data(m1_read_data), .m1_err(m1_err), .m1_busy(m1_busy),
    .dram_addr(dram_addr), .dram_read_en(dram_read_en), .dram_write_en(dram_write_en),
    .dram_byte_enable(dram_byte_enable), .dram_write_data(dram_write_data),
    .dram_ack(dram_ack), .dram_read_data(dram_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm, input int p);
    n_checks++;
    n_fail++;
    $display("FAIL %s port %0d at cycle %0d: got event, expected none", nm, p, cyc);
  endtask

  // DRAM contents as seen by reads: a fixed function of the address
  function automatic logic [DW-1:0] rd_pattern(input logic [AW-1:0] a);
    return {a[9:0], a} ^ 32'h5A3C_96E1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read_en = 1'b0; m0_write_en = 1'b0;
    m1_read_en = 1'b0; m1_write_en = 1'b0;
  endtask

  task automatic drive(input int p, input logic wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (p == 0) begin
      m0_addr = a; m0_read_en = ~wr; m0_write_en = wr; m0_byte_enable = be; m0_write_data = d;
    end else begin
      m1_addr = a; m1_read_en = ~wr; m1_write_en = wr; m1_byte_enable = be; m1_write_data = d;
    end
  endtask

  task automatic send(input int p, input logic wr, input logic [AW-1:0] a,
                      input logic [BW-1:0] be, input logic [DW-1:0] d,
                      input int icyc, input int acyc, input logic eerr,
                      input logic [DW-1:0] rexp);
    iss_t i;
    ack_t k;
    i.addr = a; i.be = be; i.data = d; i.wr = wr; i.cyc = icyc;
    k.err = eerr; k.rdata = (wr || eerr) ? '0 : rexp; k.cyc = acyc;
    iss_q[p].push_back(i);
    ack_q[p].push_back(k);
    drive(p, wr, a, be, d);
  endtask

  task automatic wait_done(input int max);
    int i;
    i = 0;
    while (i < max && (iss_q[0].size() + iss_q[1].size() + ack_q[0].size() +
                       ack_q[1].size() + ovf_q[0].size() + ovf_q[1].size()) != 0) begin
      tick();
      i++;
    end
    if (i >= max) fail_evt("wait_budget", 0);
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m0"}, {m0_ack, m0_err, m0_busy, m0_read_data}, '0);
    chk({tag, "_m1"}, {m1_ack, m1_err, m1_busy, m1_read_data}, '0);
    chk({tag, "_strobes"}, {dram_read_en, dram_write_en}, '0);
    chk({tag, "_dram_addr"}, dram_addr, '0);
    chk({tag, "_dram_be_data"}, {dram_byte_enable, dram_write_data}, '0);
  endtask

  // DRAM responder: checks each strobe against the expected issue and acks later
  always @(negedge clk) begin : responder
    iss_t e;
    int   p;
    dram_ack = 1'b0;
    dram_read_data = '0;
    if (reset) begin
      resp_pending = 1'b0;
    end else begin
      if (dram_read_en || dram_write_en) begin
        p = int'(dram_addr[AW-1]);
        chk("strobe_exclusive", dram_read_en & dram_write_en, 1'b0);
        if (iss_q[p].size() == 0) begin
          fail_evt("extra_strobe", p);
        end else begin
          e = iss_q[p].pop_front();
          chk("dram_addr", dram_addr, e.addr);
          chk("dram_write_en", dram_write_en, e.wr);
          chk("dram_be", dram_byte_enable, e.be);
          chk("dram_wdata", dram_write_data, e.data);
          if (e.cyc >= 0) chk("issue_cycle", cyc, e.cyc);
          if (order_q.size() != 0) chk("grant_order", p, order_q.pop_front());
          chk("starvation", skip[p] > 1, 1'b0);
          skip[p] = 0;
          if (iss_q[1-p].size() != 0) skip[1-p]++;
        end
        resp_pending = 1'b1;
        resp_addr    = dram_addr;
        resp_cnt     = rand_delay ? int'($urandom_range(0, 20)) : resp_delay;
      end
      if (late_ack) begin
        dram_ack = 1'b1;
        dram_read_data = 32'hBAD0_BAD0;
      end else if (resp_pending && resp_en) begin
        if (resp_cnt == 0) begin
          dram_ack = 1'b1;
          dram_read_data = use_fixed ? fixed_data : rd_pattern(resp_addr);
          resp_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end
    end
  end

  // Completion monitor: pops per-port expectations whenever ack/err pulses
  always @(negedge clk) begin : monitor
    ack_t e;
    int   oc;
    if (m0_ack || m1_ack) chk("dual_ack", m0_ack & m1_ack, 1'b0);
    for (int p = 0; p < 2; p++) begin
      if (ack_v[p]) begin
        if (ack_q[p].size() == 0) begin
          fail_evt("unexpected_ack", p);
        end else begin
          e = ack_q[p].pop_front();
          chk("ack_err", err_v[p], e.err);
          chk("ack_rdata", rd_v[p], e.rdata);
          if (e.cyc >= 0) chk("ack_cycle", cyc, e.cyc);
        end
      end else if (err_v[p]) begin
        if (ovf_q[p].size() == 0) begin
          fail_evt("unexpected_err", p);
        end else begin
          oc = ovf_q[p].pop_front();
          chk("overflow_cycle", cyc, oc);
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    int sent [2];
    logic [AW-1:0] a;
    reset = 1'b1; sync_reset = 1'b0;
    m0_addr = '0; m0_byte_enable = '0; m0_write_data = '0;
    m1_addr = '0; m1_byte_enable = '0; m1_write_data = '0;
    idle_inputs();
    resp_en = 1'b1; rand_delay = 1'b0; use_fixed = 1'b0; late_ack = 1'b0;
    resp_delay = 0; fixed_data = '0; skip[0] = 0; skip[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("in_reset");
    reset = 1'b0;
    tick();
    check_zero("after_reset");

    // First tie after reset: m0 write then m1 read, back to back
    n = cyc;
    send(0, 1'b1, A0W, 4'b0011, 32'hCAFE_F00D, n + 2, n + 3, 1'b0, '0);
    send(1, 1'b0, A1R, 4'hF, 32'h0, n + 4, n + 5, 1'b0, rd_pattern(A1R));
    order_q.push_back(0); order_q.push_back(1);
    tick(); idle_inputs();
    wait_done(50);

    // Single read on m0 with minimum latency
    use_fixed = 1'b1; fixed_data = 32'h1234_5678;
    n = cyc;
    send(0, 1'b0, A0R, 4'h0, 32'h0, n + 2, n + 3, 1'b0, 32'h1234_5678);
    tick(); idle_inputs();
    wait_done(50);
    use_fixed = 1'b0;

    // Tie with last_grant = 0: m1 goes first
    n = cyc;
    send(0, 1'b1, A0R, 4'b1100, 32'h0BAD_BEEF, n + 4, n + 5, 1'b0, '0);
    send(1, 1'b0, A1B, 4'hF, 32'h0, n + 2, n + 3, 1'b0, rd_pattern(A1B));
    order_q.push_back(1); order_q.push_back(0);
    tick(); idle_inputs();
    wait_done(50);

    // Overflow: second m1 pulse while busy is dropped with m1_err only
    resp_delay = 5;
    n = cyc;
    send(1, 1'b0, A1R, 4'hF, 32'h0, n + 2, n + 8, 1'b0, rd_pattern(A1R));
    tick(); idle_inputs();
    chk("m1_busy_after_capture", m1_busy, 1'b1);
    tick(); tick();
    drive(1, 1'b0, A1B, 4'hF, 32'h0);
    ovf_q[1].push_back(n + 4);
    tick(); idle_inputs();
    wait_done(50);
    resp_delay = 0;

    // Timeout with no dram_ack, then a late ack, then a normal request
    resp_en = 1'b0;
    n = cyc;
    send(0, 1'b0, A0R, 4'hF, 32'h0, n + 2, n + 2 + TO, 1'b1, '0);
    tick(); idle_inputs();
    wait_done(TO + 20);
    late_ack = 1'b1;
    tick();
    late_ack = 1'b0;
    resp_en = 1'b1;
    repeat (3) tick();
    resp_delay = 3;
    n = cyc;
    send(0, 1'b1, A0W, 4'b0101, 32'h1357_9BDF, n + 2, n + 6, 1'b0, '0);
    tick(); idle_inputs();
    wait_done(50);

    // Async reset during WAIT: outputs clear at once, no ack, m0 wins next tie
    resp_delay = 10;
    n = cyc;
    send(0, 1'b0, A0R, 4'hF, 32'h0, n + 2, -1, 1'b0, rd_pattern(A0R));
    tick(); idle_inputs();
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    ack_q[0].delete();
    tick(); tick();
    reset = 1'b0;
    tick();
    resp_delay = 0;
    n = cyc;
    send(0, 1'b0, A0R, 4'hF, 32'h0, n + 2, n + 3, 1'b0, rd_pattern(A0R));
    send(1, 1'b1, A1B, 4'b1000, 32'hA5A5_0001, n + 4, n + 5, 1'b0, '0);
    order_q.push_back(0); order_q.push_back(1);
    tick(); idle_inputs();
    wait_done(50);

    // Synchronous clear during WAIT behaves like reset on the next edge
    resp_delay = 10;
    n = cyc;
    send(1, 1'b0, A1R, 4'hF, 32'h0, n + 2, -1, 1'b0, rd_pattern(A1R));
    tick(); idle_inputs();
    repeat (3) tick();
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    ack_q[1].delete();
    chk("sync_reset_m1_busy", m1_busy, 1'b0);
    chk("sync_reset_dram_addr", dram_addr, '0);
    repeat (12) tick();
    resp_delay = 0;

    // Randomised traffic on both ports with 0..20 cycle DRAM latency
    rand_delay = 1'b1;
    sent[0] = 0; sent[1] = 0;
    for (int c = 0; c < 30000; c++) begin
      if (sent[0] == NR && sent[1] == NR && ack_q[0].size() == 0 && ack_q[1].size() == 0)
        break;
      idle_inputs();
      for (int p = 0; p < 2; p++) begin
        if (ack_q[p].size() == 0 && sent[p] < NR && $urandom_range(0, 3) != 0) begin
          a = AW'($urandom);
          a[AW-1] = 1'(p);
          send(p, 1'($urandom), a, BW'($urandom), DW'($urandom), -1, -1, 1'b0, rd_pattern(a));
          sent[p]++;
        end
      end
      tick();
    end
    idle_inputs();
    wait_done(100);
    chk("random_sent_m0", sent[0], NR);
    chk("random_sent_m1", sent[1], NR);
    chk("queues_drained", iss_q[0].size() + iss_q[1].size() + ack_q[0].size() +
                          ack_q[1].size() + ovf_q[0].size() + ovf_q[1].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
